uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Byte-stream serializer that drives the board-level `tx_data` pin of FPGA_top.
- Accepts result bytes from the inference/readout logic over a valid/ready handshake and buffers them in a small FIFO.
- Emits each byte as a UART 8N1 frame (LSB first) at a fixed baud divider.
- Gated by the top-level `enb`: while `enb` is low, no new frame starts.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 16: byte buffer entries; power of two, ≥ 2.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of `fifo_count`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- enb  in  1  frame-start enable; level-sensitive.
- in_data  in  8  byte to transmit.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  FIFO can accept; equals (`fifo_count` < FIFO_DEPTH).
- tx_data  out  1  UART serial line, idle high.
- busy  out  1  high while a frame is on the line (start through stop).
- fifo_count  out  CNT_W  bytes currently buffered, excluding the byte being shifted.

Behaviour:
- **Reset** (rst=0 at an edge, regardless of state):
  - `tx_data`=1, `busy`=0, `fifo_count`=0, `in_ready`=1.
  - FSM goes to IDLE; bit/baud counters cleared; FIFO flushed.
  - A reset mid-frame aborts the frame: the line returns high on that edge and no partial bits follow.
- **Push:** on an edge with `in_valid`=1 and `in_ready`=1, the byte is written and `fifo_count` increments.
  - `in_valid` with `in_ready`=0 is ignored; the byte is not stored and no error is raised.
  - `in_ready` is combinational from `fifo_count` and does not look ahead to a same-cycle pop. When full, a same-edge pop still blocks the push.
- **Pop:** occurs only on the FSM transition into START. A push and a pop on the same edge leave `fifo_count` unchanged.
  - Empty FIFO with a same-edge push: no pop that edge; the byte is popped on the next eligible edge.
- **FSM states:** IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1 in each bit slot.
  - **IDLE:** `tx_data`=1, `busy`=0. If `enb`=1 and FIFO non-empty: pop the head into the shift register and go to START.
  - **START:** `tx_data`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - **DATA:** `tx_data`=shift[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7 (LSB first). After bit 7's slot, go to STOP.
  - **STOP:** `tx_data`=1 for CLKS_PER_BIT cycles. At the end of the slot:
    - if `enb`=1 and FIFO non-empty: pop and go directly to START (back-to-back, zero idle gap);
    - else go to IDLE.
- `busy`=1 in START, DATA and STOP.
- **Latency:** acceptance edge E with IDLE and empty FIFO → pop at edge E+1 → `tx_data` low from E+1 for CLKS_PER_BIT cycles.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are seamless.
- **enb deasserted mid-frame:** the current frame completes normally and no further pop occurs until `enb`=1. Buffered bytes are retained.
- `tx_data`, `busy` and the shift register are registered outputs; no combinational path from `in_*` to `tx_data`.
- FIFO pointers wrap modulo FIFO_DEPTH. `fifo_count` never exceeds FIFO_DEPTH and never underflows.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- **Reset/idle:** hold rst=0 for 5 cycles, then release with `in_valid`=0 → `tx_data`=1, `busy`=0, `in_ready`=1, `fifo_count`=0 for 100 cycles.
- **Single byte:** `enb`=1, push 0xA5 at edge E → `tx_data` low for cycles E+1..E+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; `busy` high for exactly 40 cycles.
- **Back-to-back / full:**
  - Push 0x00, 0xFF, 0x55, 0x3C, 0x81 on consecutive cycles (`enb`=1). The first byte pops at once, so 4 more fit; `in_ready` drops when `fifo_count`=4 and a 6th push is refused.
  - Line shows 5 contiguous frames (200 cycles) with no idle cycle between stop and start; received bytes match push order.
- **enb gating:** `enb`=0, push 0x12, 0x34 → `fifo_count`=2, `tx_data` stays 1. Raise `enb` → two frames 0x12, 0x34.
  - Drop `enb` during the first frame's DATA → 0x12 completes, 0x34 is held, `fifo_count`=1.
- **Reset mid-frame:** assert rst=0 during bit 3 of 0xC3 with 2 bytes queued → next edge `tx_data`=1, `busy`=0, `fifo_count`=0. After release, no frame appears without a new push.
- **Boundary push/pop:**
  - Push on the same edge as the STOP→START pop while `fifo_count`=2 → count stays 2.
  - With FIFO full, push on the pop edge → push refused, count becomes 3.

Source files
------------

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// Purpose:
//   Serialises result bytes onto the board-level UART transmit pin. Bytes are
//   accepted over a valid/ready handshake into a small FIFO and shifted out
//   as 8N1 frames (start bit, 8 data bits LSB first, one stop bit) at a fixed
//   baud divider. A new frame only starts while `enb` is high. A frame that
//   is already on the line always completes, unless reset aborts it.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit slot (>= 2)
//   FIFO_DEPTH    byte buffer entries (power of two, >= 2)
//   CNT_W         width of fifo_count ($clog2(FIFO_DEPTH)+1)
//
// Ports:
//   clk         in   system clock, all logic on the rising edge
//   rst         in   synchronous reset, active-low
//   enb         in   frame-start enable, level-sensitive
//   in_data     in   byte to transmit
//   in_valid    in   in_data valid
//   in_ready    out  FIFO can accept (fifo_count < FIFO_DEPTH)
//   tx_data     out  UART serial line, idle high (registered)
//   busy        out  high while a frame is on the line (registered)
//   fifo_count  out  bytes buffered, excluding the byte being shifted
// -----------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_data,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [AW-1:0]     PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]     PTR_ONE   = AW'(1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0]        BIT_ZERO  = 3'd0;
    localparam logic [2:0]        BIT_ONE   = 3'd1;
    localparam logic [2:0]        BIT_LAST  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [7:0]        fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_nxt_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_nxt_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_nxt_s;
    logic              tx_r;
    logic              tx_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;

    // -------------------------------------------------------------------------
    // Handshake / status terms
    // -------------------------------------------------------------------------
    logic              fifo_empty_s;
    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              slot_end_s;
    logic              can_pop_s;

    // FIFO status and handshake qualifiers, all derived from registered state.
    // in_ready deliberately ignores a same-edge pop: a full FIFO refuses the
    // push even on the edge that frees an entry.
    always_comb begin
        fifo_empty_s = (count_r == CNT_ZERO);
        in_ready_s   = (count_r < CNT_DEPTH);
        push_s       = in_valid & in_ready_s;
        slot_end_s   = (baud_r == BAUD_LAST);
        can_pop_s    = enb & ~fifo_empty_s;
    end

    // Next-state logic for the frame FSM, baud counter, bit index and shifter.
    // A pop only ever happens on a transition into START.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        pop_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                baud_nxt_s    = BAUD_ZERO;
                bit_idx_nxt_s = BIT_ZERO;
                if (can_pop_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_mem_r[rd_ptr_r];
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (slot_end_s) begin
                    baud_nxt_s    = BAUD_ZERO;
                    bit_idx_nxt_s = BIT_ZERO;
                    state_nxt_s   = ST_DATA;
                end else begin
                    baud_nxt_s    = baud_r + BAUD_ONE;
                end
            end

            ST_DATA: begin
                if (slot_end_s) begin
                    baud_nxt_s = BAUD_ZERO;
                    if (bit_idx_r == BIT_LAST) begin
                        bit_idx_nxt_s = BIT_ZERO;
                        state_nxt_s   = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + BIT_ONE;
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end

            ST_STOP: begin
                if (slot_end_s) begin
                    baud_nxt_s    = BAUD_ZERO;
                    bit_idx_nxt_s = BIT_ZERO;
                    // Chain straight into the next start bit when data is
                    // waiting, so consecutive frames have no idle gap.
                    if (can_pop_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = fifo_mem_r[rd_ptr_r];
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end

            default: begin
                baud_nxt_s    = BAUD_ZERO;
                bit_idx_nxt_s = BIT_ZERO;
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // Line level and busy flag for the upcoming cycle, decoded from the next
    // state so that both outputs can be registered without a cycle of skew.
    always_comb begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = 1'b0;

        case (state_nxt_s)
            ST_IDLE: begin
                tx_nxt_s   = 1'b1;
                busy_nxt_s = 1'b0;
            end
            ST_START: begin
                tx_nxt_s   = 1'b0;
                busy_nxt_s = 1'b1;
            end
            ST_DATA: begin
                tx_nxt_s   = shift_nxt_s[bit_idx_nxt_s];
                busy_nxt_s = 1'b1;
            end
            ST_STOP: begin
                tx_nxt_s   = 1'b1;
                busy_nxt_s = 1'b1;
            end
            default: begin
                tx_nxt_s   = 1'b1;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Frame FSM and output registers; reset aborts any frame in flight and
    // returns the line high on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= BIT_ZERO;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two; a simultaneous push and pop leaves the count as is.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO data array; contents need no reset since the pointers define
    // which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            fifo_mem_r[wr_ptr_r] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign in_ready   = in_ready_s;
    assign tx_data    = tx_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Directed bench for uart_tx_framer with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// The stimulus side pushes each byte it expects to see on the line into a
// scoreboard queue; an independent UART receiver decodes frames from tx_data
// and compares them against the queue head. A second monitor measures the
// length of each contiguous busy run so frame length and back-to-back
// chaining can be checked directly.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rst;
    logic          enb;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          tx_data;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int            n_checks;
    int            n_fail;
    logic [7:0]    exp_q[$];
    int            run_len;
    int            last_run;

    uart_tx_framer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_data   (tx_data),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one byte for a single edge; exp_rdy is the hand-derived in_ready.
    task automatic push(input logic [7:0] d, input bit exp_rdy);
        in_valid = 1'b1;
        in_data  = d;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (exp_rdy) exp_q.push_back(d);
        @(negedge clk);
    endtask

    // Wait (bounded) until busy is low, optionally also requiring an empty FIFO.
    task automatic wait_done(input string name, input bit need_empty, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (busy === 1'b0 && (!need_empty || fifo_count == 3'd0)) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k < 4)       return 1'b0;
        else if (k < 36) return b[(k - 4) / 4];
        else             return 1'b1;
    endfunction

    // Expected idle snapshot {tx_data, busy, in_ready, fifo_count}.
    task automatic check_idle(input string name);
        check(name, {26'd0, tx_data, busy, in_ready, fifo_count}, {26'd0, 6'b101000});
    endtask

    // UART receiver: samples each bit slot in its middle and scores the byte.
    initial begin : rx_monitor
        int         idx;
        bit         act;
        bit         frame_ok;
        logic [7:0] rx_b;
        logic [7:0] want;
        idx = 0; act = 1'b0; frame_ok = 1'b1; rx_b = 8'h00; want = 8'h00;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx_data === 1'b0) begin
                    act = 1'b1; idx = 1; frame_ok = 1'b1; rx_b = 8'h00;
                end
            end else begin
                if (idx == 2 && tx_data !== 1'b0) frame_ok = 1'b0;
                if (idx >= 4 && idx < 36 && (idx % 4) == 2) rx_b[(idx - 4) / 4] = tx_data;
                if (idx == 38 && tx_data !== 1'b1) frame_ok = 1'b0;
                if (idx == 39) begin
                    act = 1'b0;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rx_frame: got unexpected byte 0x%02h, expected no frame", rx_b);
                    end else begin
                        want = exp_q.pop_front();
                        if (rx_b !== want || !frame_ok) begin
                            n_fail++;
                            $display("FAIL rx_frame: got 0x%02h framing_ok=%0d, expected 0x%02h framing_ok=1",
                                     rx_b, frame_ok, want);
                        end
                    end
                end else begin
                    idx++;
                end
            end
        end
    end

    // Busy run-length monitor.
    initial begin : busy_monitor
        run_len = 0; last_run = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                run_len++;
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    initial begin : stimulus
        n_checks = 0; n_fail = 0;
        rst = 1'b0; enb = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // Reset and idle
        repeat (5) @(negedge clk);
        check_idle("reset_state");
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_idle("idle_after_reset");
        end

        // Single byte 0xA5: exact line waveform and 40-cycle busy
        enb = 1'b1;
        push(8'hA5, 1'b1);
        in_valid = 1'b0;
        check("single_count_after_push", {29'd0, fifo_count}, 32'd1);
        check("single_tx_before_start", {31'd0, tx_data}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("single_line", {30'd0, tx_data, busy}, {30'd0, frame_bit(8'hA5, k), 1'b1});
        end
        @(negedge clk);
        check("single_end", {30'd0, tx_data, busy}, {30'd0, 2'b10});
        @(negedge clk);
        check("single_busy_len", last_run, 32'd40);

        // Back-to-back frames and FIFO full
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h55, 1'b1);
        push(8'h3C, 1'b1);
        push(8'h81, 1'b1);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        push(8'h99, 1'b0);
        in_valid = 1'b0;
        wait_done("b2b_done", 1'b1, 400);
        @(negedge clk);
        check("b2b_busy_len", last_run, 32'd200);

        // enb gating, including enb dropped mid-frame
        enb = 1'b0;
        push(8'h12, 1'b1);
        push(8'h34, 1'b1);
        in_valid = 1'b0;
        check("gated_count", {29'd0, fifo_count}, 32'd2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("gated_line_idle", {30'd0, tx_data, busy}, {30'd0, 2'b10});
        end
        enb = 1'b1;
        repeat (10) @(negedge clk);
        enb = 1'b0;
        wait_done("gated_first_done", 1'b0, 100);
        @(negedge clk);
        check("gated_first_len", last_run, 32'd40);
        check("gated_held_count", {29'd0, fifo_count}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("gated_hold", {29'd0, tx_data, busy, 1'b0} | {30'd0, fifo_count[1:0]},
                  {29'd0, 3'b101});
        end
        enb = 1'b1;
        wait_done("gated_second_done", 1'b1, 200);
        @(negedge clk);
        check("gated_second_len", last_run, 32'd40);

        // Reset during bit 3 of 0xC3 with two bytes queued
        push(8'hC3, 1'b1);
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        in_valid = 1'b0;
        check("abort_queued", {29'd0, fifo_count}, 32'd2);
        repeat (16) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("abort_reset_edge");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check_idle("abort_no_frame");
        end

        // Push on the STOP->START pop edge, then a full FIFO on the pop edge
        push(8'hA1, 1'b1);
        push(8'hB2, 1'b1);
        push(8'hC3, 1'b1);
        in_valid = 1'b0;
        repeat (38) @(negedge clk);
        check("edge_count_before", {29'd0, fifo_count}, 32'd2);
        push(8'hD4, 1'b1);
        check("edge_push_pop_count", {29'd0, fifo_count}, 32'd2);
        push(8'hE5, 1'b1);
        push(8'hF6, 1'b1);
        in_valid = 1'b0;
        check("edge_full_count", {29'd0, fifo_count}, 32'd4);
        repeat (37) @(negedge clk);
        push(8'h77, 1'b0);
        in_valid = 1'b0;
        check("edge_full_pop_count", {29'd0, fifo_count}, 32'd3);
        wait_done("edge_done", 1'b1, 1000);
        @(negedge clk);
        check("edge_busy_len", last_run, 32'd240);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
